// File: rtl/udc_pkg.sv
// Shared types and constants for the updown_counter_pro block.
// Optional feature macro used by the top: UDC_EVENT_CNT_EN (boundary-hit event counter).
package udc_pkg;

    // Run-control states of the counter
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } udc_state_e;

    // Width of the optional boundary-hit event counter
    localparam int UDC_EVT_W = 16;

    // Direction encodings for the m input
    localparam logic UDC_UP = 1'b0;
    localparam logic UDC_DN = 1'b1;

endpackage : udc_pkg

// File: rtl/udc_next_calc.sv
// Combinational next-count and boundary-hit computation for updown_counter_pro.
// Arithmetic runs one bit wider than the widest operand so that a step past
// the top of the range or below zero is detected rather than truncated.
module udc_next_calc
    import udc_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic [WIDTH-1:0]  count,
    input  logic [STEP_W-1:0] eff_step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              m,
    input  logic              wrap,
    output logic [WIDTH-1:0]  next_count,
    output logic              hit
);

    localparam int CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

    logic [CW-1:0] cnt_x_s;
    logic [CW-1:0] step_x_s;
    logic [CW-1:0] min_x_s;
    logic [CW-1:0] max_x_s;
    logic [CW-1:0] sum_s;
    logic [CW-1:0] floor_s;

    assign cnt_x_s  = {{(CW-WIDTH){1'b0}}, count};
    assign step_x_s = {{(CW-STEP_W){1'b0}}, eff_step};
    assign min_x_s  = {{(CW-WIDTH){1'b0}}, min_val};
    assign max_x_s  = {{(CW-WIDTH){1'b0}}, max_val};
    assign sum_s    = cnt_x_s + step_x_s;
    // Smallest count that can still step down without leaving the window
    assign floor_s  = min_x_s + step_x_s;

    // Pick the next count: out-of-window clamps first, then up/down stepping with wrap or saturate
    always_comb begin
        next_count = count;
        hit        = 1'b0;
        if (count > max_val) begin
            next_count = max_val;
            hit        = 1'b1;
        end else if (count < min_val) begin
            next_count = min_val;
            hit        = 1'b1;
        end else if (m == UDC_UP) begin
            if (sum_s > max_x_s) begin
                hit        = 1'b1;
                next_count = wrap ? min_val : max_val;
            end else begin
                next_count = sum_s[WIDTH-1:0];
            end
        end else begin
            if (cnt_x_s < floor_s) begin
                hit        = 1'b1;
                next_count = wrap ? max_val : min_val;
            end else begin
                // No hit means eff_step <= count, so it fits in WIDTH bits
                next_count = count - step_x_s[WIDTH-1:0];
            end
        end
    end

endmodule : udc_next_calc

// File: rtl/updown_counter_pro.sv
// Bounded up/down counter with programmable step and window, wrap or
// saturate at the bounds, one-shot run mode and status flags.
// Optional macro UDC_EVENT_CNT_EN adds a saturating boundary-hit counter
// output evt_cnt, cleared on load.
module updown_counter_pro
    import udc_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int STEP_W  = 4,
    parameter int RST_VAL = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              m,
    input  logic              load,
    input  logic [WIDTH-1:0]  data_in,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  min_val,
    input  logic [WIDTH-1:0]  max_val,
    input  logic              wrap,
    input  logic              oneshot,
    output logic [WIDTH-1:0]  count,
    output logic              tc,
    output logic              at_max,
    output logic              at_min,
    output logic              busy,
    output logic              cfg_err
`ifdef UDC_EVENT_CNT_EN
    ,
    output logic [UDC_EVT_W-1:0] evt_cnt
`endif
);

    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);

    udc_state_e        state_r;
    udc_state_e        state_nxt_s;
    logic [WIDTH-1:0]  count_r;
    logic [WIDTH-1:0]  count_nxt_s;
    logic              tc_r;
    logic              tc_nxt_s;
    logic [STEP_W-1:0] eff_step_s;
    logic [WIDTH-1:0]  calc_next_s;
    logic              calc_hit_s;
    logic [WIDTH-1:0]  load_val_s;
    logic              cfg_err_s;

    assign cfg_err_s  = (min_val > max_val);
    assign eff_step_s = (step == {STEP_W{1'b0}}) ? STEP_W'(1'b1) : step;

    udc_next_calc #(
        .WIDTH  (WIDTH),
        .STEP_W (STEP_W)
    ) u_next_calc (
        .count      (count_r),
        .eff_step   (eff_step_s),
        .min_val    (min_val),
        .max_val    (max_val),
        .m          (m),
        .wrap       (wrap),
        .next_count (calc_next_s),
        .hit        (calc_hit_s)
    );

    // Clamp the load value into the current window
    always_comb begin
        load_val_s = data_in;
        if (data_in < min_val) begin
            load_val_s = min_val;
        end else if (data_in > max_val) begin
            load_val_s = max_val;
        end else begin
            load_val_s = data_in;
        end
    end

    // Next-state, next-count and terminal-count decision; bad config freezes everything
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        tc_nxt_s    = 1'b0;
        if (cfg_err_s) begin
            state_nxt_s = IDLE;
        end else if (load) begin
            count_nxt_s = load_val_s;
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                DONE: begin
                    state_nxt_s = DONE;
                end
                IDLE, RUN: begin
                    if (en) begin
                        count_nxt_s = calc_next_s;
                        tc_nxt_s    = calc_hit_s;
                        if (calc_hit_s && oneshot) begin
                            state_nxt_s = DONE;
                        end else begin
                            state_nxt_s = RUN;
                        end
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Counter, state and terminal-count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            count_r <= RST_COUNT;
            tc_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            tc_r    <= tc_nxt_s;
        end
    end

`ifdef UDC_EVENT_CNT_EN
    logic [UDC_EVT_W-1:0] evt_r;

    // Saturating boundary-hit counter, cleared by an accepted load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_r <= {UDC_EVT_W{1'b0}};
        end else if (!cfg_err_s && load) begin
            evt_r <= {UDC_EVT_W{1'b0}};
        end else if (tc_nxt_s && (evt_r != {UDC_EVT_W{1'b1}})) begin
            evt_r <= evt_r + {{(UDC_EVT_W-1){1'b0}}, 1'b1};
        end else begin
            evt_r <= evt_r;
        end
    end

    assign evt_cnt = evt_r;
`endif

    assign count   = count_r;
    assign tc      = tc_r;
    assign busy    = (state_r == RUN);
    assign at_max  = (count_r == max_val);
    assign at_min  = (count_r == min_val);
    assign cfg_err = cfg_err_s;

endmodule : updown_counter_pro

// File: tb/tb_updown_counter_pro.sv
// Self-checking bench for updown_counter_pro: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_updown_counter_pro;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       m;
    logic       load;
    logic [7:0] data_in;
    logic [3:0] step;
    logic [7:0] min_val;
    logic [7:0] max_val;
    logic       wrap;
    logic       oneshot;
    logic [7:0] count;
    logic       tc;
    logic       at_max;
    logic       at_min;
    logic       busy;
    logic       cfg_err;
`ifdef UDC_EVENT_CNT_EN
    logic [15:0] evt_cnt;
`endif

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    updown_counter_pro #(
        .WIDTH   (8),
        .STEP_W  (4),
        .RST_VAL (0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .m       (m),
        .load    (load),
        .data_in (data_in),
        .step    (step),
        .min_val (min_val),
        .max_val (max_val),
        .wrap    (wrap),
        .oneshot (oneshot),
        .count   (count),
        .tc      (tc),
        .at_max  (at_max),
        .at_min  (at_min),
        .busy    (busy),
        .cfg_err (cfg_err)
`ifdef UDC_EVENT_CNT_EN
        ,
        .evt_cnt (evt_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: count value, running / stopped flags, tc, event total
    typedef struct packed {
        int cnt;
        bit run;
        bit done;
        bit tc;
        int evt;
    } mdl_t;

    mdl_t mdl;

    function automatic mdl_t model_next(input mdl_t c, input bit ld, input bit en_i,
                                        input bit dir, input bit wr, input bit os,
                                        input int din, input int st, input int mn, input int mx);
        mdl_t n = c;
        int   es;
        int   nxt;
        bit   hit;
        n.tc = 1'b0;
        if (mn > mx) begin
            n.run  = 1'b0;
            n.done = 1'b0;
        end else if (ld) begin
            n.cnt  = (din < mn) ? mn : ((din > mx) ? mx : din);
            n.run  = 1'b0;
            n.done = 1'b0;
            n.evt  = 0;
        end else if (c.done) begin
            n.done = 1'b1;
        end else if (!en_i) begin
            n.run = 1'b0;
        end else begin
            es  = (st == 0) ? 1 : st;
            hit = 1'b0;
            nxt = c.cnt;
            if (c.cnt > mx) begin
                hit = 1'b1; nxt = mx;
            end else if (c.cnt < mn) begin
                hit = 1'b1; nxt = mn;
            end else if (!dir) begin
                if (c.cnt + es > mx) begin hit = 1'b1; nxt = wr ? mn : mx; end
                else nxt = c.cnt + es;
            end else begin
                if (c.cnt - es < mn) begin hit = 1'b1; nxt = wr ? mx : mn; end
                else nxt = c.cnt - es;
            end
            n.cnt  = nxt;
            n.tc   = hit;
            if (hit && (n.evt < 65535)) n.evt = n.evt + 1;
            n.done = hit && os;
            n.run  = !(hit && os);
        end
        return n;
    endfunction

    // Advance the model alongside the DUT, including asynchronous reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdl.cnt  <= 0;
            mdl.run  <= 1'b0;
            mdl.done <= 1'b0;
            mdl.tc   <= 1'b0;
            mdl.evt  <= 0;
        end else begin
            mdl <= model_next(mdl, load, en, m, wrap, oneshot,
                              int'(data_in), int'(step), int'(min_val), int'(max_val));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model, away from the active edge
    always @(negedge clk) begin
        if (check_on) begin
            chk("m_count",   32'(count),   32'(mdl.cnt));
            chk("m_tc",      32'(tc),      32'(mdl.tc));
            chk("m_busy",    32'(busy),    32'(mdl.run));
            chk("m_at_max",  32'(at_max),  32'(mdl.cnt == int'(max_val)));
            chk("m_at_min",  32'(at_min),  32'(mdl.cnt == int'(min_val)));
            chk("m_cfg_err", 32'(cfg_err), 32'(int'(min_val) > int'(max_val)));
`ifdef UDC_EVENT_CNT_EN
            chk("m_evt_cnt", 32'(evt_cnt), 32'(mdl.evt));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b0; m = 1'b0; load = 1'b0; data_in = 8'd0;
        step = 4'd1; min_val = 8'd0; max_val = 8'd255; wrap = 1'b1; oneshot = 1'b0;
        #1 rst_n = 1'b0;
        check_on = 1'b1;
        tick();
        // Reset and basic up count
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_tc",    32'(tc),    32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        en = 1'b1;
        tick();
        rst_n = 1'b1;
        tick(); chk("up1", 32'(count), 32'd1);
        tick(); chk("up2", 32'(count), 32'd2);
        tick(); chk("up3", 32'(count), 32'd3);
        chk("up_tc", 32'(tc), 32'd0);
        chk("up_busy", 32'(busy), 32'd1);

        // Wrap up past the top of the range
        load = 1'b1; data_in = 8'd250; en = 1'b0;
        tick(); chk("wrap_load", 32'(count), 32'd250);
        load = 1'b0; step = 4'd4; en = 1'b1;
        tick(); chk("wrap_254", 32'(count), 32'd254);
        tick(); chk("wrap_min", 32'(count), 32'd0);
        chk("wrap_tc", 32'(tc), 32'd1);
`ifdef UDC_EVENT_CNT_EN
        chk("wrap_evt", 32'(evt_cnt), 32'd1);
`endif
        en = 1'b0;
        tick(); chk("wrap_tc_off", 32'(tc), 32'd0);

        // Saturating down count
        wrap = 1'b0; min_val = 8'd10; m = 1'b1; step = 4'd2; load = 1'b1; data_in = 8'd13;
        tick(); chk("sat_load", 32'(count), 32'd13);
        load = 1'b0; en = 1'b1;
        tick(); chk("sat_11", 32'(count), 32'd11); chk("sat_tc0", 32'(tc), 32'd0);
        tick(); chk("sat_10a", 32'(count), 32'd10); chk("sat_tc1", 32'(tc), 32'd1);
        tick(); chk("sat_10b", 32'(count), 32'd10); chk("sat_tc2", 32'(tc), 32'd1);
        chk("sat_at_min", 32'(at_min), 32'd1);
        en = 1'b0;

        // One-shot run
        oneshot = 1'b1; min_val = 8'd0; max_val = 8'd5; wrap = 1'b1; m = 1'b0; step = 4'd1;
        load = 1'b1; data_in = 8'd3;
        tick(); chk("os_load", 32'(count), 32'd3);
        load = 1'b0; en = 1'b1;
        tick(); chk("os_4", 32'(count), 32'd4);
        tick(); chk("os_5", 32'(count), 32'd5);
        tick(); chk("os_0", 32'(count), 32'd0); chk("os_tc", 32'(tc), 32'd1);
        chk("os_done_busy", 32'(busy), 32'd0);
        tick(); chk("os_hold", 32'(count), 32'd0); chk("os_hold_tc", 32'(tc), 32'd0);
        load = 1'b1; data_in = 8'd2;
        tick(); chk("os_reload", 32'(count), 32'd2); chk("os_idle", 32'(busy), 32'd0);
        oneshot = 1'b0;

        // Load priority and clamping, then step 0 counts by one
        max_val = 8'd100; data_in = 8'd200;
        tick(); chk("clamp", 32'(count), 32'd100); chk("clamp_tc", 32'(tc), 32'd0);
        load = 1'b0; max_val = 8'd200; step = 4'd0;
        tick(); chk("step0_a", 32'(count), 32'd101); chk("step0_busy", 32'(busy), 32'd1);
        tick(); chk("step0_b", 32'(count), 32'd102);

        // Configuration error freezes the counter
        min_val = 8'd50; max_val = 8'd40;
        #1 chk("cfg_err", 32'(cfg_err), 32'd1);
        tick(); chk("cfg_hold", 32'(count), 32'd102); chk("cfg_busy", 32'(busy), 32'd0);
        load = 1'b1; data_in = 8'd7;
        tick(); chk("cfg_noload", 32'(count), 32'd102);
        load = 1'b0; min_val = 8'd0; max_val = 8'd255; step = 4'd1;
        tick(); chk("cfg_resume", 32'(count), 32'd103); chk("cfg_run", 32'(busy), 32'd1);

        // Reset in the middle of a run takes effect without a clock
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_tc",   32'(tc),   32'd0);
        tick();
        rst_n = 1'b1;

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
            load    = ($urandom_range(0, 99) < 8);
            en      = ($urandom_range(0, 9) != 0);
            data_in = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) m = ~m;
            if ($urandom_range(0, 15) == 0) wrap = ~wrap;
            if ($urandom_range(0, 15) == 0) oneshot = ~oneshot;
            if ($urandom_range(0, 7) == 0) step = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 31) == 0) begin
                min_val = 8'($urandom_range(0, 200));
                max_val = 8'(int'(min_val) + $urandom_range(0, 55));
                if ($urandom_range(0, 9) == 0) begin
                    data_in = min_val; min_val = max_val; max_val = data_in;
                end
            end
        end

        tick();
        check_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_updown_counter_pro

// File: doc/updown_counter_pro.md
Name: updown_counter_pro

Overview:
Parametrised successor to the team's 8-bit load/up/down counter.
- Adds programmable step, programmable min/max window, and wrap or saturate boundary handling.
- Adds a one-shot run mode driven by a small FSM, plus terminal-count and status flags.
- Sits in timer, prescaler and address-sequencing paths wherever a bounded, reloadable count is needed.

Parameters:
- WIDTH, 8, count/data/bound width (2..32).
- STEP_W, 4, width of step input; step value 0 is treated as 1.
- RST_VAL, 0, count value after reset; must lie within the power-on bounds.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  count enable; advances once per cycle while set.
- m  in  1  direction: 0 = up, 1 = down.
- load  in  1  synchronous load of data_in; highest priority after reset.
- data_in  in  WIDTH  load value.
- step  in  STEP_W  increment/decrement magnitude.
- min_val  in  WIDTH  lower bound, inclusive.
- max_val  in  WIDTH  upper bound, inclusive.
- wrap  in  1  1 = wrap at bound, 0 = saturate at bound.
- oneshot  in  1  1 = stop in DONE after first boundary hit.
- count  out  WIDTH  current count, registered.
- tc  out  1  one-cycle pulse on a boundary hit.
- at_max  out  1  count == max_val (combinational from the count register).
- at_min  out  1  count == min_val.
- busy  out  1  FSM in RUN.
- cfg_err  out  1  min_val > max_val.

Behaviour:
- Reset (async, rst_n low):
  - count = RST_VAL, tc = 0.
  - FSM = IDLE.
  - Reset mid-count aborts immediately; no pending tc.
- FSM states: IDLE, RUN, DONE (encoding from package).
  - IDLE -> RUN when en=1 and load=0.
  - RUN -> IDLE when en=0.
  - RUN -> DONE on a boundary hit while oneshot=1.
  - DONE -> IDLE only on load; DONE ignores en and holds count.
  - Any state: load=1 -> IDLE next cycle (count loads).
  - busy = (state == RUN).
- Counting happens on every cycle where load=0 and en=1 and state is not DONE, including the IDLE->RUN transition cycle.
  - Latency from en rising to first count change: one clock.
- Load:
  - count <= data_in clamped to [min_val, max_val].
  - load beats en in the same cycle.
  - tc = 0 on a load cycle.
- Arithmetic:
  - eff_step = (step == 0) ? 1 : step, zero-extended.
  - Compute in WIDTH+1 bits so overflow past 2^WIDTH−1 and underflow below 0 are detected, never silently truncated.
- Up (m=0):
  - If count + eff_step > max_val, a boundary hit occurs.
  - wrap=1: next = min_val.
  - wrap=0: next = max_val.
- Down (m=1):
  - If count < min_val + eff_step (underflow-safe compare), a boundary hit occurs.
  - wrap=1: next = max_val.
  - wrap=0: next = min_val.
- Saturated hold: an enabled cycle at max (up) or min (down) with wrap=0 counts as a boundary hit every cycle, so tc pulses each cycle.
- tc: registered, asserted the cycle after the boundary-hit cycle, deasserted otherwise.
- Direction change mid-run takes effect on the next enabled edge, with no bubble.
- Bounds or step changed mid-run: the new values are used on the next enabled edge.
  - If count lies outside the new window, the next enabled step clamps count into the window and flags a boundary hit.
- cfg_err=1: count holds (no load, no count), FSM forced to IDLE, tc = 0.
- min_val == max_val is legal: every enabled cycle is a boundary hit and count stays put.

Optional Feature:
- Macro: UDC_EVENT_CNT_EN.
- Defined:
  - Adds output evt_cnt [15:0], reset to 0.
  - Increments on every boundary hit and saturates at 16'hFFFF.
  - Cleared on load.
- Undefined: port absent, no added logic.
- All other behaviour is identical either way.

Decomposition:
- Package udc_pkg holds:
  - typedef enum logic [1:0] udc_state_e {IDLE, RUN, DONE}.
  - localparam UDC_EVT_W = 16.
  - Direction constants UDC_UP = 1'b0, UDC_DN = 1'b1.
- Sub-module udc_next_calc: purely combinational.
  - Inputs: count, eff_step, bounds, m, wrap.
  - Outputs: next_count, hit.
  - Keeps the top block to FSM plus registers.

Test Plan:
- Reset/basic up: rst_n low, RST_VAL=0, min=0, max=255, step=1, wrap=1, en=1 for 3 cycles -> count 1, 2, 3; tc=0.
- Wrap up: load 250, step=4, max=255 -> 254, then 0 (min) with tc pulse; evt_cnt=1 when the macro is defined.
- Saturate down: wrap=0, min=10, load 13, step=2, m=1 -> 11, 10, 10; tc pulses on both the 10 cycles; at_min=1.
- One-shot: oneshot=1, min=0, max=5, load 3, en=1 -> 4, 5, 0, DONE; count holds at 0 despite en; load 2 -> IDLE, count=2.
- Priority and clamp: load=1, en=1, data_in=200, max=100 -> count=100, tc=0; step=0 then counts by 1.
- Config error and mid-run reset: min=50, max=40 -> cfg_err=1, count frozen; drop rst_n mid-RUN -> count=RST_VAL immediately, busy=0.
